// File: rtl/alu_64.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | alu_64 : single-cycle registered add/sub/and/xor ALU with flags       |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module alu_64 #(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [1:0]       control,
  input  logic             in_valid,
  output logic [WIDTH-1:0] out,
  output logic             overflow,
  output logic             zero,
  output logic             sign,
  output logic             out_valid
);

  localparam logic [1:0] c_OP_ADD = 2'b00;
  localparam logic [1:0] c_OP_SUB = 2'b01;
  localparam logic [1:0] c_OP_AND = 2'b10;

  logic             w_is_sub;
  logic [WIDTH-1:0] w_b_eff;
  logic [WIDTH-1:0] w_sum;
  logic [WIDTH-1:0] w_result;
  logic             w_overflow;

  // Subtract reuses the adder as a + ~b + 1, so one overflow rule covers both.
  always_comb begin
    w_is_sub   = (control == c_OP_SUB);
    w_b_eff    = w_is_sub ? ~b : b;
    w_sum      = a + w_b_eff + {{(WIDTH-1){1'b0}}, w_is_sub};
    w_result   = w_sum;
    w_overflow = 1'b0;
    case (control)
      c_OP_ADD, c_OP_SUB: begin
        w_result   = w_sum;
        w_overflow = (a[WIDTH-1] == w_b_eff[WIDTH-1]) &&
                     (w_sum[WIDTH-1] != a[WIDTH-1]);
      end
      c_OP_AND: w_result = a & b;
      default:  w_result = a ^ b;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out       <= '0;
      overflow  <= 1'b0;
      zero      <= 1'b1;
      sign      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        out      <= w_result;
        overflow <= w_overflow;
        zero     <= (w_result == '0);
        sign     <= w_result[WIDTH-1];
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_alu_64.sv
`default_nettype none
// Scoreboard bench for alu_64: directed vectors queued at issue, popped by a monitor on out_valid.
module tb_alu_64;

  typedef struct {
    logic [63:0] res;
    logic        ovf;
    logic        z;
    logic        s;
    string       name;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [63:0] a;
  logic [63:0] b;
  logic [1:0]  control;
  logic        in_valid;
  logic [63:0] out;
  logic        overflow;
  logic        zero;
  logic        sign;
  logic        out_valid;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;
  int   pushed = 0;
  int   popped = 0;
  bit   mon_en = 1'b0;

  alu_64 #(.WIDTH(64)) dut (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .control(control),
    .in_valid(in_valid), .out(out), .overflow(overflow), .zero(zero),
    .sign(sign), .out_valid(out_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Drive one operation at the current time and queue its hand-computed result.
  task automatic drive(input string name, input logic [63:0] ta, input logic [63:0] tb_v,
                       input logic [1:0] c, input logic [63:0] er, input logic eo);
    exp_t e;
    a        = ta;
    b        = tb_v;
    control  = c;
    in_valid = 1'b1;
    e.res  = er;
    e.ovf  = eo;
    e.z    = (er == 64'd0);
    e.s    = er[63];
    e.name = name;
    sb.push_back(e);
    pushed++;
  endtask

  task automatic issue(input string name, input logic [63:0] ta, input logic [63:0] tb_v,
                       input logic [1:0] c, input logic [63:0] er, input logic eo);
    @(negedge clk);
    drive(name, ta, tb_v, c, er, eo);
  endtask

  always @(negedge clk) begin
    if (mon_en && out_valid !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        fails++;
        $display("FAIL unexpected_out_valid: got out_valid=%b out=%h expected no output", out_valid, out);
      end else begin
        exp_t e;
        e = sb.pop_front();
        popped++;
        chk({e.name, ".out"},       out,      e.res);
        chk({e.name, ".overflow"},  {63'd0, overflow}, {63'd0, e.ovf});
        chk({e.name, ".zero"},      {63'd0, zero},     {63'd0, e.z});
        chk({e.name, ".sign"},      {63'd0, sign},     {63'd0, e.s});
      end
    end
  end

  initial begin
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 64'd1;
    b        = 64'd1;
    control  = 2'b00;
    repeat (2) @(negedge clk);
    chk("reset.out",       out,                64'd0);
    chk("reset.zero",      {63'd0, zero},      64'd1);
    chk("reset.overflow",  {63'd0, overflow},  64'd0);
    chk("reset.sign",      {63'd0, sign},      64'd0);
    chk("reset.out_valid", {63'd0, out_valid}, 64'd0);
    mon_en = 1'b1;
    rst_n  = 1'b1;
    drive("add_5_3", 64'd5, 64'd3, 2'b00, 64'd8, 1'b0);

    issue("sub_100_8",  64'h100, 64'd8, 2'b01, 64'hF8, 1'b0);
    issue("sub_8_8",    64'd8,   64'd8, 2'b01, 64'd0,  1'b0);
    issue("add_ovf",    64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'h8000_0000_0000_0000, 1'b1);
    issue("sub_ovf",    64'h8000_0000_0000_0000, 64'd1, 2'b01, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1);
    issue("and_f0f0",   64'hF0F0, 64'hFF00, 2'b10, 64'hF000, 1'b0);
    issue("xor_f0f0",   64'hF0F0, 64'hFF00, 2'b11, 64'h0FF0, 1'b0);
    issue("add_carry",  64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 2'b00, 64'd0, 1'b0);
    issue("sub_borrow", 64'd0, 64'd1, 2'b01, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    issue("sub_negb",   64'h7FFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 2'b01,
          64'h8000_0000_0000_0000, 1'b1);
    issue("add_minmin", 64'h8000_0000_0000_0000, 64'h8000_0000_0000_0000, 2'b00, 64'd0, 1'b1);
    issue("and_ones",   64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_00FF, 2'b10,
          64'h8000_0000_0000_00FF, 1'b0);
    issue("add_hold",   64'h10, 64'h20, 2'b00, 64'h30, 1'b0);

    // Inputs change while idle; registered outputs must not move.
    @(negedge clk);
    in_valid = 1'b0;
    a        = 64'hDEAD;
    b        = 64'hBEEF;
    control  = 2'b11;
    @(negedge clk);
    chk("hold.out",       out,                64'h30);
    chk("hold.out_valid", {63'd0, out_valid}, 64'd0);
    chk("hold.zero",      {63'd0, zero},      64'd0);

    issue("add_pre_rst", 64'd7, 64'd9, 2'b00, 64'd16, 1'b0);
    @(negedge clk);
    rst_n    = 1'b0;
    in_valid = 1'b1;
    a        = 64'd1;
    b        = 64'd1;
    control  = 2'b00;
    @(negedge clk);
    chk("midrst.out",       out,                64'd0);
    chk("midrst.zero",      {63'd0, zero},      64'd1);
    chk("midrst.out_valid", {63'd0, out_valid}, 64'd0);
    chk("midrst.sign",      {63'd0, sign},      64'd0);
    rst_n = 1'b1;
    drive("add_post_rst", 64'd2, 64'd2, 2'b00, 64'd4, 1'b0);

    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    chk("sb_count",   64'(popped),    64'(pushed));

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/alu_64.md
ALU_64 -- requirements
Module: alu_64

Interface
REQ-001 The block SHALL expose parameter WIDTH, default 64, the operand and result width in bits; all requirements below are stated for WIDTH=64.
REQ-002 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-003 Port rst_n, input, 1 bit: reset, synchronous and active-low, sampled on the clk rising edge.
REQ-004 Port a, input, WIDTH bits: first operand (minuend for subtract).
REQ-005 Port b, input, WIDTH bits: second operand (subtrahend for subtract).
REQ-006 Port control, input, 2 bits: operation select (00 add, 01 sub, 10 and, 11 xor).
REQ-007 Port in_valid, input, 1 bit: when high, a, b and control are captured this edge.
REQ-008 Port out, output, WIDTH bits: registered result.
REQ-009 Port overflow, output, 1 bit: registered two's-complement signed overflow of the captured operation.
REQ-010 Port zero, output, 1 bit: registered, high when out is all zeros.
REQ-011 Port sign, output, 1 bit: registered, equal to out[WIDTH-1].
REQ-012 Port out_valid, output, 1 bit: registered, high for one cycle after each accepted operation.

Function
REQ-013 control=00 SHALL produce out = (a + b) mod 2^WIDTH; the carry-out is discarded.
REQ-014 control=01 SHALL produce out = (a - b) mod 2^WIDTH, computed as a + ~b + 1.
REQ-015 control=10 SHALL produce out = a AND b, bitwise.
REQ-016 control=11 SHALL produce out = a XOR b, bitwise.
REQ-017 For add, overflow SHALL be 1 iff a[MSB]==b[MSB] and result[MSB]!=a[MSB].
REQ-018 For sub, overflow SHALL be 1 iff a[MSB]!=b[MSB] and result[MSB]!=a[MSB].
REQ-019 For and/xor, overflow SHALL be 0.
REQ-020 zero and sign SHALL be derived from the same result that is registered into out, in the same cycle.
REQ-021 Latency SHALL be exactly one clock: operands sampled with in_valid=1 at edge N appear on out, overflow, zero, sign with out_valid=1 after edge N.
REQ-022 Back-to-back operations SHALL be accepted every cycle; there is no stall and no backpressure input.
REQ-023 When in_valid=0 at an edge, out, overflow, zero and sign SHALL hold their previous values and out_valid SHALL go to 0.
REQ-024 Changes to a, b or control between edges SHALL NOT affect the outputs until the next capturing edge; no combinational path from inputs to outputs.

Reset
REQ-025 When rst_n=0 at a rising edge, out SHALL be 0, overflow 0, sign 0, out_valid 0 and zero 1 (consistent with out=0), regardless of in_valid.
REQ-026 Reset SHALL take priority over a simultaneous in_valid=1; the operation presented in that cycle is discarded.
REQ-027 The first operation with in_valid=1 on the edge after rst_n returns high SHALL be processed normally with one-cycle latency.

Verification
REQ-028 Add: a=5, b=3, control=00, in_valid=1 -> next cycle out=8, overflow=0, zero=0, sign=0, out_valid=1.
REQ-029 Sub/stack decrement: a=0x100, b=8, control=01 -> out=0xF8, flags 0; a=8, b=8, control=01 -> out=0, zero=1.
REQ-030 Overflow: a=0x7FFF_FFFF_FFFF_FFFF, b=1, control=00 -> out=0x8000_0000_0000_0000, overflow=1, sign=1; a=0x8000_0000_0000_0000, b=1, control=01 -> out=0x7FFF_FFFF_FFFF_FFFF, overflow=1, sign=0.
REQ-031 Logic: a=0xF0F0, b=0xFF00, control=10 -> out=0xF000; control=11 -> out=0x0FF0; overflow=0 in both.
REQ-032 Hold: one valid add, then in_valid=0 with changed a and b -> out unchanged, out_valid=0.
REQ-033 Reset mid-stream: rst_n=0 with in_valid=1, a=1, b=1 -> next cycle out=0, zero=1, out_valid=0; release and issue a=2, b=2, control=00 -> out=4 one cycle later.
